// File: rtl/range_sum_caller_if.sv
// Handshake bundle for range_sum_caller: parent call/result side plus the child generator side.
// The slave modport is the caller block; master is whatever drives its parent and child inputs.
interface range_sum_caller_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SUM_WIDTH = 48,
  parameter int unsigned CNT_WIDTH = 16
);
  // Parent side
  logic                        _start;
  logic signed [WIDTH-1:0]     base;
  logic signed [WIDTH-1:0]     limit;
  logic signed [WIDTH-1:0]     step;
  logic                        _ready;
  logic                        _valid;
  logic                        _done;
  logic signed [SUM_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        count;
  logic                        timeout;

  // Child generator side
  logic                        child_start;
  logic signed [WIDTH-1:0]     child_base;
  logic signed [WIDTH-1:0]     child_limit;
  logic signed [WIDTH-1:0]     child_step;
  logic                        child_ready;
  logic                        child_valid;
  logic                        child_done;
  logic signed [WIDTH-1:0]     child_0;

  modport slave (
    input  _start, base, limit, step, _ready, child_valid, child_done, child_0,
    output _valid, _done, sum, count, timeout,
    output child_start, child_base, child_limit, child_step, child_ready
  );

  modport master (
    output _start, base, limit, step, _ready, child_valid, child_done, child_0,
    input  _valid, _done, sum, count, timeout,
    input  child_start, child_base, child_limit, child_step, child_ready
  );
endinterface

// File: rtl/range_sum_caller.sv
// Launches a child range generator, sums every yielded beat under a rotating ready pattern,
// and hands the signed sum, beat count and timeout flag back to the parent as one result beat.
module range_sum_caller #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SUM_WIDTH  = 48,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter logic [3:0]  READY_MASK = 4'b1111,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic               _clock,
  input logic               _reset_n,
  range_sum_caller_if.slave bus
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  if (READY_MASK == 4'b0000) begin : g_bad_mask
    $error("range_sum_caller: READY_MASK must be nonzero");
  end
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("range_sum_caller: TIMEOUT must be nonzero");
  end
  if (SUM_WIDTH < WIDTH) begin : g_bad_sum_width
    $error("range_sum_caller: SUM_WIDTH must be at least WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StCall, StCollect, StReport} state_e;

  state_e                      state_q, state_d;
  logic signed [WIDTH-1:0]     base_q, base_d;
  logic signed [WIDTH-1:0]     limit_q, limit_d;
  logic signed [WIDTH-1:0]     step_q, step_d;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic [CNT_WIDTH-1:0]        count_q, count_d;
  logic                        timeout_q, timeout_d;
  logic [1:0]                  phase_q, phase_d;
  logic [IdleW-1:0]            idle_q, idle_d;

  logic                        ready;
  logic                        beat;
  logic [IdleW-1:0]            idle_inc;
  logic signed [SUM_WIDTH-1:0] beat_ext;

  assign ready    = (state_q == StCollect) && READY_MASK[phase_q];
  assign beat     = ready && bus.child_valid;
  assign idle_inc = idle_q + IdleW'(1);
  assign beat_ext = SUM_WIDTH'($signed(bus.child_0));

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q   <= StIdle;
      base_q    <= '0;
      limit_q   <= '0;
      step_q    <= '0;
      sum_q     <= '0;
      count_q   <= '0;
      timeout_q <= 1'b0;
      phase_q   <= '0;
      idle_q    <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      limit_q   <= limit_d;
      step_q    <= step_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      timeout_q <= timeout_d;
      phase_q   <= phase_d;
      idle_q    <= idle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    limit_d   = limit_q;
    step_d    = step_q;
    sum_d     = sum_q;
    count_d   = count_q;
    timeout_d = timeout_q;
    phase_d   = phase_q;
    idle_d    = idle_q;

    unique case (state_q)
      StIdle: begin
        if (bus._start) begin
          base_d    = bus.base;
          limit_d   = bus.limit;
          step_d    = bus.step;
          sum_d     = '0;
          count_d   = '0;
          timeout_d = 1'b0;
          state_d   = StCall;
        end
      end
      StCall: begin
        phase_d = '0;
        idle_d  = '0;
        state_d = StCollect;
      end
      StCollect: begin
        phase_d = phase_q + 2'd1;
        if (beat) begin
          sum_d   = sum_q + beat_ext;
          count_d = count_q + CNT_WIDTH'(1);
          idle_d  = '0;
        end else begin
          idle_d  = idle_inc;
        end
        // A beat riding along with done is already folded into sum_d above.
        if (ready && bus.child_done) begin
          state_d = StReport;
        end else if (!beat && idle_inc == IdleW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          state_d   = StReport;
        end
      end
      StReport: begin
        if (bus._ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus._done       = (state_q == StIdle);
  assign bus._valid      = (state_q == StReport);
  assign bus.sum         = sum_q;
  assign bus.count       = count_q;
  assign bus.timeout     = timeout_q;
  assign bus.child_start = (state_q == StCall);
  assign bus.child_base  = base_q;
  assign bus.child_limit = limit_q;
  assign bus.child_step  = step_q;
  assign bus.child_ready = ready;

endmodule

// File: tb/tb_range_sum_caller.sv
// Bench for range_sum_caller: two instances (full and alternating ready mask) share one
// behavioural range generator; expected results are queued at launch and popped at handoff.
module tb_range_sum_caller;

  localparam logic [3:0] MaskA = 4'b1111;
  localparam logic [3:0] MaskB = 4'b0101;
  localparam int         ToCyc = 16;

  typedef struct {
    logic signed [47:0] sum;
    logic [15:0]        cnt;
    logic               to;
  } res_t;

  logic clk;
  logic rst_n;

  range_sum_caller_if #(.WIDTH(32), .SUM_WIDTH(48), .CNT_WIDTH(16)) if_a ();
  range_sum_caller_if #(.WIDTH(32), .SUM_WIDTH(48), .CNT_WIDTH(16)) if_b ();

  range_sum_caller #(
    .WIDTH(32), .SUM_WIDTH(48), .CNT_WIDTH(16), .READY_MASK(MaskA), .TIMEOUT(ToCyc)
  ) dut_a (
    ._clock  (clk),
    ._reset_n(rst_n),
    .bus     (if_a)
  );

  range_sum_caller #(
    .WIDTH(32), .SUM_WIDTH(48), .CNT_WIDTH(16), .READY_MASK(MaskB), .TIMEOUT(ToCyc)
  ) dut_b (
    ._clock  (clk),
    ._reset_n(rst_n),
    .bus     (if_b)
  );

  // Parent-side drive; sel picks which instance is exercised.
  logic               sel;
  logic               p_start;
  logic               p_ready;
  logic signed [31:0] p_base, p_limit, p_step;
  int                 mode;  // 0 normal, 1 done with last beat, 2 stall

  assign if_a._start = p_start && !sel;
  assign if_b._start = p_start && sel;
  assign if_a._ready = p_ready && !sel;
  assign if_b._ready = p_ready && sel;
  assign if_a.base   = p_base;
  assign if_b.base   = p_base;
  assign if_a.limit  = p_limit;
  assign if_b.limit  = p_limit;
  assign if_a.step   = p_step;
  assign if_b.step   = p_step;

  logic               r_valid, r_done, r_to, r_cstart, m_ready;
  logic signed [47:0] r_sum;
  logic [15:0]        r_count;
  logic signed [31:0] r_cbase, r_climit, r_cstep;

  assign r_valid  = sel ? if_b._valid      : if_a._valid;
  assign r_done   = sel ? if_b._done       : if_a._done;
  assign r_to     = sel ? if_b.timeout     : if_a.timeout;
  assign r_sum    = sel ? if_b.sum         : if_a.sum;
  assign r_count  = sel ? if_b.count       : if_a.count;
  assign r_cstart = sel ? if_b.child_start : if_a.child_start;
  assign r_cbase  = sel ? if_b.child_base  : if_a.child_base;
  assign r_climit = sel ? if_b.child_limit : if_a.child_limit;
  assign r_cstep  = sel ? if_b.child_step  : if_a.child_step;
  assign m_ready  = sel ? if_b.child_ready : if_a.child_ready;

  // Behavioural range generator shared by both instances.
  logic               c_active, c_valid, c_done;
  logic signed [31:0] c_cur, c_lim, c_stp;

  function automatic logic in_rng(input logic signed [31:0] x, input logic signed [31:0] lim,
                                  input logic signed [31:0] stp);
    if (stp > 0) return x < lim;
    if (stp < 0) return x > lim;
    return 1'b0;
  endfunction

  always_comb begin
    c_valid = 1'b0;
    c_done  = 1'b0;
    if (c_active && mode != 2) begin
      c_valid = in_rng(c_cur, c_lim, c_stp);
      c_done  = !in_rng(c_cur, c_lim, c_stp) ||
                (mode == 1 && !in_rng(c_cur + c_stp, c_lim, c_stp));
    end
  end

  assign if_a.child_valid = c_valid;
  assign if_b.child_valid = c_valid;
  assign if_a.child_done  = c_done;
  assign if_b.child_done  = c_done;
  assign if_a.child_0     = c_cur;
  assign if_b.child_0     = c_cur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_active <= 1'b0;
      c_cur    <= '0;
      c_lim    <= '0;
      c_stp    <= '0;
    end else if (r_cstart) begin
      c_active <= 1'b1;
      c_cur    <= r_cbase;
      c_lim    <= r_climit;
      c_stp    <= r_cstep;
    end else if (c_active) begin
      if (c_valid && m_ready) c_cur <= c_cur + c_stp;
      if (c_done && m_ready)  c_active <= 1'b0;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic res_t exp_range(input logic signed [31:0] b, input logic signed [31:0] l,
                                     input logic signed [31:0] s);
    res_t               r;
    logic signed [31:0] x;
    int                 guard;
    r.sum = '0;
    r.cnt = '0;
    r.to  = 1'b0;
    x     = b;
    guard = 0;
    while (in_rng(x, l, s) && guard < 1000) begin
      r.sum = r.sum + 48'(x);
      r.cnt = r.cnt + 16'd1;
      x     = x + s;
      guard++;
    end
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},    64'(r_done),   64'(1));
    check({tag, "_valid"},   64'(r_valid),  64'(0));
    check({tag, "_cstart"},  64'(r_cstart), 64'(0));
    check({tag, "_cready"},  64'(m_ready),  64'(0));
    check({tag, "_sum"},     64'(r_sum),    64'(0));
    check({tag, "_count"},   64'(r_count),  64'(0));
    check({tag, "_timeout"}, 64'(r_to),     64'(0));
    check({tag, "_cbase"},   64'(r_cbase),  64'(0));
  endtask

  // Called on a negedge; returns on the negedge where the instance sits in CALL.
  task automatic start_call(input logic s, input int b, input int l, input int st, input int md);
    res_t e;
    sel     = s;
    mode    = md;
    p_base  = b;
    p_limit = l;
    p_step  = st;
    if (md == 2) begin
      e.sum = '0;
      e.cnt = '0;
      e.to  = 1'b1;
    end else begin
      e = exp_range(b, l, st);
    end
    exp_q.push_back(e);
    p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    check("call_cstart", 64'(r_cstart), 64'(1));
    check("call_cready", 64'(m_ready),  64'(0));
    check("call_busy",   64'(r_done),   64'(0));
    check("call_cbase",  64'(r_cbase),  64'(b));
    check("call_climit", 64'(r_climit), 64'(l));
    check("call_cstep",  64'(r_cstep),  64'(st));
  endtask

  task automatic wait_result(input logic no_ack, input int hold);
    logic [3:0] msk;
    logic [1:0] ph;
    int         k, k_done;
    logic       got;
    res_t       e;
    msk    = sel ? MaskB : MaskA;
    k      = 0;
    k_done = -1;
    got    = 1'b0;
    while (!got && k < 200) begin
      @(negedge clk);
      if (r_valid) begin
        got = 1'b1;
      end else begin
        ph = 2'(k);
        if (c_active) check("collect_ready", 64'(m_ready), 64'(msk[ph]));
        if (c_done && m_ready) k_done = k;
        k++;
      end
    end
    if (!got) begin
      check("result_valid", 64'(0), 64'(1));
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return;
    end
    e = exp_q.pop_front();
    if (mode == 2) check("timeout_latency", 64'(k), 64'(ToCyc));
    else check("done_to_valid", 64'(k_done >= 0 && k - k_done <= 2), 64'(1));
    check("res_sum",     64'(r_sum),   64'(e.sum));
    check("res_count",   64'(r_count), 64'(e.cnt));
    check("res_timeout", 64'(r_to),    64'(e.to));
    if (no_ack) return;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(r_valid), 64'(1));
      check("hold_sum",   64'(r_sum),   64'(e.sum));
    end
    p_ready = 1'b1;
    @(negedge clk);
    p_ready = 1'b0;
    check("ack_valid", 64'(r_valid), 64'(0));
    check("ack_done",  64'(r_done),  64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    sel     = 1'b0;
    mode    = 0;
    p_start = 1'b0;
    p_ready = 1'b0;
    p_base  = '0;
    p_limit = '0;
    p_step  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_a");
    sel = 1'b1;
    #1;
    check_reset_outputs("rst_b");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic range, full ready mask
    start_call(1'b0, 0, 10, 2, 0);
    wait_result(1'b0, 2);
    // Empty range
    start_call(1'b0, 5, 5, 1, 0);
    wait_result(1'b0, 0);
    // Descending range, alternating ready
    start_call(1'b1, 10, 0, -3, 0);
    wait_result(1'b0, 1);
    // Last beat arrives together with done
    start_call(1'b0, 0, 3, 1, 1);
    wait_result(1'b0, 0);
    start_call(1'b1, 1, 6, 2, 1);
    wait_result(1'b0, 0);
    // Negative partial sums
    start_call(1'b0, -5, 5, 3, 0);
    wait_result(1'b0, 0);
    // Stalled child ends by timeout
    start_call(1'b0, 0, 10, 1, 2);
    wait_result(1'b0, 0);

    // Reset mid-collect
    start_call(1'b0, 0, 100, 1, 0);
    repeat (5) @(negedge clk);
    check("pre_reset_sum", 64'(r_sum != 0), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_collect");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a result waits unaccepted
    start_call(1'b0, 0, 3, 1, 0);
    wait_result(1'b1, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_report");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_call(1'b0, 0, 4, 1, 0);
    wait_result(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
